// File: rtl/hazard_unit.sv
// hazard_unit: stall/bubble/hold sequencing and operand forwarding select for a 5-stage pipeline.
// Optional feature: define FORWARDING_EN to forward MEM/WB results so that only EX load-use stalls.
module hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_src_reg_num_1,
  input  logic [4:0]  id_src_reg_num_2,
  input  logic        id_src_used_1,
  input  logic        id_src_used_2,
  input  logic [4:0]  ex_dst_reg_num,
  input  logic [4:0]  mem_dst_reg_num,
  input  logic [4:0]  wb_dst_reg_num,
  input  logic        ex_reg_write_enable,
  input  logic        mem_reg_write_enable,
  input  logic        wb_reg_write_enable,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        ex_mc_start,
  input  logic        ex_mc_done,
  output logic        if_hold,
  output logic        ex_bubble,
  output logic        ex_hold,
  output logic        pc_offset,
  output logic [1:0]  forward_sel_1,
  output logic [1:0]  forward_sel_2,
  output logic [15:0] stall_cycles
);

  // state   | meaning
  // RUN     | normal issue; hazards, branches and multicycle starts are evaluated
  // STALL   | remaining bubble cycles of a multi-cycle stall, counted down by cnt
  // WAIT_MC | pipeline frozen until the multicycle unit reports done
  typedef enum logic [1:0] {RUN, STALL, WAIT_MC} state_t;

  state_t     state;
  logic [1:0] cnt;
  logic       ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic [1:0] stall_len;
  logic [1:0] fs1, fs2;
  logic       hazard;
  logic       if_hold_c, ex_bubble_c, ex_hold_c, pc_offset_c;

  assign ex_m1  = id_src_used_1 && ex_reg_write_enable  && (ex_dst_reg_num  != 5'd0) && (id_src_reg_num_1 == ex_dst_reg_num);
  assign ex_m2  = id_src_used_2 && ex_reg_write_enable  && (ex_dst_reg_num  != 5'd0) && (id_src_reg_num_2 == ex_dst_reg_num);
  assign mem_m1 = id_src_used_1 && mem_reg_write_enable && (mem_dst_reg_num != 5'd0) && (id_src_reg_num_1 == mem_dst_reg_num);
  assign mem_m2 = id_src_used_2 && mem_reg_write_enable && (mem_dst_reg_num != 5'd0) && (id_src_reg_num_2 == mem_dst_reg_num);
  assign wb_m1  = id_src_used_1 && wb_reg_write_enable  && (wb_dst_reg_num  != 5'd0) && (id_src_reg_num_1 == wb_dst_reg_num);
  assign wb_m2  = id_src_used_2 && wb_reg_write_enable  && (wb_dst_reg_num  != 5'd0) && (id_src_reg_num_2 == wb_dst_reg_num);

`ifdef FORWARDING_EN
  always_comb begin
    stall_len = (ex_mem_read && (ex_m1 || ex_m2)) ? 2'd1 : 2'd0;
    fs1 = mem_m1 ? 2'b01 : (wb_m1 ? 2'b10 : 2'b00);
    fs2 = mem_m2 ? 2'b01 : (wb_m2 ? 2'b10 : 2'b00);
  end
`else
  // Without forwarding the load flag is irrelevant: every producer match stalls.
  logic unused_ex_mem_read;
  assign unused_ex_mem_read = ex_mem_read;

  always_comb begin
    fs1 = 2'b00;
    fs2 = 2'b00;
    if (ex_m1 || ex_m2)        stall_len = 2'd3;
    else if (mem_m1 || mem_m2) stall_len = 2'd2;
    else if (wb_m1 || wb_m2)   stall_len = 2'd1;
    else                       stall_len = 2'd0;
  end
`endif

  assign hazard = (stall_len != 2'd0);

  always_comb begin
    if_hold_c   = 1'b0;
    ex_bubble_c = 1'b0;
    ex_hold_c   = 1'b0;
    pc_offset_c = 1'b0;
    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          pc_offset_c = 1'b1;
        end else if (hazard) begin
          if_hold_c   = 1'b1;
          ex_bubble_c = 1'b1;
        end else if (ex_mc_start) begin
          if_hold_c = 1'b1;
          ex_hold_c = 1'b1;
        end
      end
      STALL: begin
        if (ex_branch_taken) begin
          pc_offset_c = 1'b1;
        end else begin
          if_hold_c   = 1'b1;
          ex_bubble_c = 1'b1;
        end
      end
      WAIT_MC: begin
        if (!ex_mc_done) begin
          if_hold_c = 1'b1;
          ex_hold_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset gates the control outputs directly so they drop without waiting for a clock.
  assign if_hold       = rst_n && if_hold_c;
  assign ex_bubble     = rst_n && ex_bubble_c;
  assign ex_hold       = rst_n && ex_hold_c;
  assign pc_offset     = rst_n && pc_offset_c;
  assign forward_sel_1 = rst_n ? fs1 : 2'b00;
  assign forward_sel_2 = rst_n ? fs2 : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (!ex_branch_taken) begin
            if (hazard) begin
              if (stall_len > 2'd1) begin
                cnt   <= stall_len - 2'd1;
                state <= STALL;
              end
            end else if (ex_mc_start) begin
              state <= WAIT_MC;
            end
          end
        end
        STALL: begin
          if (ex_branch_taken) begin
            cnt   <= 2'd0;
            state <= RUN;
          end else begin
            cnt <= cnt - 2'd1;
            if (cnt <= 2'd1) state <= RUN;
          end
        end
        WAIT_MC: begin
          if (ex_mc_done) state <= RUN;
        end
        default: begin
          cnt   <= 2'd0;
          state <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= 16'd0;
    else if (if_hold && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 id_src_reg_num_1, id_src_reg_num_2  in  5 each  ID-stage source register numbers.
REQ-004 id_src_used_1, id_src_used_2  in  1 each  the corresponding source is actually read.
REQ-005 ex_dst_reg_num, mem_dst_reg_num, wb_dst_reg_num  in  5 each  destination register numbers in EX, MEM and WB.
REQ-006 ex_reg_write_enable, mem_reg_write_enable, wb_reg_write_enable  in  1 each  the destination in that stage is written.
REQ-007 ex_mem_read  in  1  the EX instruction is a load.
REQ-008 ex_branch_taken  in  1  the EX branch condition is satisfied; a redirect is required.
REQ-009 ex_mc_start, ex_mc_done  in  1 each  the multicycle (mul/div) unit starts, or finishes with its result valid.
REQ-010 if_hold  out  1  freeze the PC and the IF/ID register.
REQ-011 ex_bubble  out  1  load a no-op into the ID/EX register.
REQ-012 ex_hold  out  1  freeze the ID/EX and EX/MEM registers.
REQ-013 pc_offset  out  1  flush IF/ID and ID/EX, and redirect the PC.
REQ-014 forward_sel_1, forward_sel_2  out  2 each  00 = register file, 01 = MEM-stage result, 10 = WB-stage result.
REQ-015 stall_cycles  out  16  saturating count of cycles in which if_hold was high.

Function
REQ-016 A match on stage S SHALL exist when all of the following hold: id_src_used_k, id_src_reg_num_k == S_dst_reg_num, S_reg_write_enable, and S_dst_reg_num != 0.
REQ-017 The FSM states SHALL be RUN, STALL, WAIT_MC; the stall counter SHALL be 2 bits.
REQ-018 In RUN, a detected hazard SHALL assert if_hold and ex_bubble combinationally in the same cycle.
REQ-019 Stall length N SHALL be taken from REQ-034/035; if N > 1, the counter SHALL load N-1 and the FSM SHALL enter STALL.
REQ-020 In STALL, if_hold and ex_bubble SHALL stay high; the counter SHALL decrement each cycle; the FSM SHALL return to RUN in the cycle after the counter reads 0.
REQ-021 In RUN, ex_mc_start SHALL move the FSM to WAIT_MC.
REQ-022 In WAIT_MC, if_hold and ex_hold SHALL be high and ex_bubble low until ex_mc_done.
REQ-023 In the ex_mc_done cycle, all holds SHALL deassert combinationally and the FSM SHALL return to RUN.
REQ-024 If ex_mc_start and ex_mc_done are high in the same RUN cycle, ex_mc_done SHALL be ignored and WAIT_MC entered.
REQ-025 ex_branch_taken SHALL drive pc_offset high in the same cycle.
REQ-026 ex_branch_taken SHALL force if_hold and ex_bubble low that cycle, clear the counter, and return STALL to RUN, because the stalled instruction is squashed.
REQ-027 ex_branch_taken SHALL be ignored in WAIT_MC.
REQ-028 When a load-use hazard and ex_mc_start coincide, the hazard SHALL take priority and ex_mc_start SHALL be ignored.
REQ-029 The forwarding select SHALL prefer MEM over WB when both match, and SHALL be 00 for register 0.
REQ-030 stall_cycles SHALL increment on every cycle with if_hold high and hold at 16'hFFFF.

Reset
REQ-031 While rst_n is low: state RUN, counter 0, stall_cycles 0.
REQ-032 While rst_n is low, if_hold, ex_bubble, ex_hold, pc_offset and forward_sel_* SHALL be forced to 0, independent of clk.
REQ-033 Reset asserted mid-stall or in WAIT_MC SHALL abandon the operation; the first cycle after release SHALL be RUN.

Configuration
REQ-034 With FORWARDING_EN defined:
- forward_sel_* SHALL follow REQ-029.
- Only a load-use match on EX (ex_mem_read high) SHALL be a hazard, with N = 1.
- MEM and WB matches SHALL be forwarded without stalling.
REQ-035 Without FORWARDING_EN:
- forward_sel_* SHALL be constant 00.
- Any match SHALL be a hazard, with N = 3 for an EX match, 2 for a MEM match, 1 for a WB match.
- When several stages match, the largest N SHALL apply.

Verification
REQ-036 FORWARDING_EN; EX lw $8 (ex_mem_read=1), ID add reading $8 -> if_hold=1, ex_bubble=1 for exactly 1 cycle; stall_cycles=1.
REQ-037 FORWARDING_EN; MEM writes $5, WB writes $5, ID reads $5 in src 2 -> forward_sel_2=01, no hold. Same with dst $0 -> forward_sel_2=00.
REQ-038 No FORWARDING_EN; EX writes $3, ID reads $3 -> if_hold high 3 consecutive cycles, then low; stall_cycles=3.
REQ-039 ex_mc_start, then ex_mc_done 7 cycles later -> if_hold and ex_hold high 7 cycles, low in the done cycle; ex_bubble stays 0.
REQ-040 No FORWARDING_EN; EX-match stall entered, ex_branch_taken on the next cycle -> pc_offset=1 and if_hold=0 that cycle, RUN next cycle.
REQ-041 rst_n pulled low in WAIT_MC between clock edges -> all outputs 0 immediately; after release, ex_mc_done alone causes no hold.
